// File: rtl/fifo_pkg.sv
// Shared sizing constants and FSM state encoding for the 4-entry FIFO controller.
package fifo_pkg;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = PTR_W + 1;

    // BAD is never entered in normal operation; it only exists so recovery is explicit.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ACTIVE = 2'b01,
        FULL   = 2'b10,
        BAD    = 2'b11
    } state_t;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping pointer counter: advances by one when en is high, rolls over at 2**W.
module fifo_ptr_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Occupancy FSM, pointer control, write gating and sticky error flag for the FIFO storage.
module fifo_ctrl
    import fifo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in_valid,
    input  logic             pop_fifo,
    output logic [PTR_W-1:0] write_ptr,
    output logic [PTR_W-1:0] read_ptr,
    output logic             wr_en,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    state_t state;
    logic   bad_state;
    logic   push_ok;
    logic   pop_ok;
    logic   ptr_rst;

    assign bad_state  = (state == BAD);
    assign fifo_full  = (state == FULL);
    assign fifo_empty = (state == EMPTY);

    // An illegal encoding blocks both requests for the single recovery cycle.
    assign push_ok = data_in_valid & ~fifo_full & ~bad_state;
    assign pop_ok  = pop_fifo & ~fifo_empty & ~bad_state;
    assign wr_en   = push_ok;
    assign ptr_rst = rst | bad_state;

    fifo_ptr_cnt #(.W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (ptr_rst),
        .en  (push_ok),
        .ptr (write_ptr)
    );

    fifo_ptr_cnt #(.W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (ptr_rst),
        .en  (pop_ok),
        .ptr (read_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if ((data_in_valid & fifo_full) | (pop_fifo & fifo_empty)) begin
                err <= 1'b1;
            end

            if (push_ok & ~pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok & ~push_ok) begin
                count <= count - CNT_W'(1);
            end

            case (state)
                EMPTY: begin
                    if (push_ok) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (push_ok & ~pop_ok & (count == CNT_W'(DEPTH - 1))) begin
                        state <= FULL;
                    end else if (pop_ok & ~push_ok & (count == CNT_W'(1))) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop_ok & ~push_ok) begin
                        state <= ACTIVE;
                    end
                end
                default: begin
                    state <= EMPTY;
                    count <= '0;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench: fifo_ctrl beside a 4x64 register file, checked with immediate assertions.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    logic             clk;
    logic             rst;
    logic             data_in_valid;
    logic             pop_fifo;
    logic [PTR_W-1:0] write_ptr;
    logic [PTR_W-1:0] read_ptr;
    logic             wr_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] count;
    logic             err;

    logic [63:0] data_in;
    logic [63:0] data_out;
    logic [63:0] mem [DEPTH];
    logic [63:0] exp_q [$];
    logic [63:0] popped;

    int checks   = 0;
    int failures = 0;

    fifo_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .data_in_valid (data_in_valid),
        .pop_fifo      (pop_fifo),
        .write_ptr     (write_ptr),
        .read_ptr      (read_ptr),
        .wr_en         (wr_en),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .count         (count),
        .err           (err)
    );

    always @(posedge clk) begin
        if (wr_en) mem[write_ptr] <= data_in;
    end
    assign data_out = mem[read_ptr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic v, input logic p, input logic [63:0] d);
        data_in_valid = v;
        pop_fifo      = p;
        data_in       = d;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        pop_fifo      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 64'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        data_in_valid = 1'b0;
        pop_fifo = 1'b0;
        data_in = '0;
        #2;

        // Reset state
        do_reset();
        chk("rst_wp", 64'(write_ptr), 64'd0);
        chk("rst_rp", 64'(read_ptr), 64'd0);
        chk("rst_cnt", 64'(count), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // 1. Fill with A0..A3
        cyc(1'b1, 1'b0, 64'hA0);
        chk("t1_wp1", 64'(write_ptr), 64'd1);
        chk("t1_cnt1", 64'(count), 64'd1);
        chk("t1_empty1", 64'(fifo_empty), 64'd0);
        cyc(1'b1, 1'b0, 64'hA1);
        chk("t1_wp2", 64'(write_ptr), 64'd2);
        cyc(1'b1, 1'b0, 64'hA2);
        chk("t1_wp3", 64'(write_ptr), 64'd3);
        chk("t1_full3", 64'(fifo_full), 64'd0);
        cyc(1'b1, 1'b0, 64'hA3);
        chk("t1_wp0", 64'(write_ptr), 64'd0);
        chk("t1_cnt4", 64'(count), 64'd4);
        chk("t1_full", 64'(fifo_full), 64'd1);
        chk("t1_dout", data_out, 64'hA0);
        chk("t1_err", 64'(err), 64'd0);

        // 2. Push into full FIFO
        data_in_valid = 1'b1;
        data_in = 64'hFF;
        #1;
        chk("t2_wr_en", 64'(wr_en), 64'd0);
        cyc(1'b1, 1'b0, 64'hFF);
        chk("t2_err", 64'(err), 64'd1);
        chk("t2_cnt", 64'(count), 64'd4);
        chk("t2_wp", 64'(write_ptr), 64'd0);
        chk("t2_dout", data_out, 64'hA0);

        // 3. Drain
        cyc(1'b0, 1'b1, 64'h0);
        chk("t3_rp1", 64'(read_ptr), 64'd1);
        chk("t3_dout1", data_out, 64'hA1);
        chk("t3_cnt3", 64'(count), 64'd3);
        chk("t3_full", 64'(fifo_full), 64'd0);
        cyc(1'b0, 1'b1, 64'h0);
        chk("t3_dout2", data_out, 64'hA2);
        cyc(1'b0, 1'b1, 64'h0);
        chk("t3_dout3", data_out, 64'hA3);
        chk("t3_cnt1", 64'(count), 64'd1);
        cyc(1'b0, 1'b1, 64'h0);
        chk("t3_rp0", 64'(read_ptr), 64'd0);
        chk("t3_empty", 64'(fifo_empty), 64'd1);
        chk("t3_cnt0", 64'(count), 64'd0);
        cyc(1'b0, 1'b1, 64'h0);
        chk("t3_err_hold", 64'(err), 64'd1);
        chk("t3_rp_hold", 64'(read_ptr), 64'd0);
        chk("t3_cnt_hold", 64'(count), 64'd0);

        // 4. Wrap-around with two held entries
        do_reset();
        exp_q.delete();
        cyc(1'b1, 1'b0, 64'hB0);
        exp_q.push_back(64'hB0);
        cyc(1'b1, 1'b0, 64'hB1);
        exp_q.push_back(64'hB1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 64'hC0 + 64'(i));
            exp_q.push_back(64'hC0 + 64'(i));
            chk("t4_cnt_push", 64'(count), 64'(exp_q.size()));
            chk("t4_head", data_out, exp_q[0]);
            popped = exp_q.pop_front();
            cyc(1'b0, 1'b1, 64'h0);
            chk("t4_cnt_pop", 64'(count), 64'(exp_q.size()));
        end
        chk("t4_wp", 64'(write_ptr), 64'd0);
        chk("t4_rp", 64'(read_ptr), 64'd2);
        chk("t4_dout", data_out, 64'hC4);
        chk("t4_last_pop", popped, 64'hC3);
        chk("t4_err", 64'(err), 64'd0);

        // 5a. Simultaneous push+pop at count 2
        cyc(1'b1, 1'b1, 64'hD0);
        chk("t5a_cnt", 64'(count), 64'd2);
        chk("t5a_wp", 64'(write_ptr), 64'd1);
        chk("t5a_rp", 64'(read_ptr), 64'd3);
        chk("t5a_dout", data_out, 64'hC5);
        chk("t5a_err", 64'(err), 64'd0);
        cyc(1'b0, 1'b1, 64'h0);
        chk("t5a_dout2", data_out, 64'hD0);
        cyc(1'b0, 1'b1, 64'h0);
        chk("t5a_empty", 64'(fifo_empty), 64'd1);
        chk("t5a_rp2", 64'(read_ptr), 64'd1);

        // 5b. Simultaneous at empty
        cyc(1'b1, 1'b1, 64'hE0);
        chk("t5b_cnt", 64'(count), 64'd1);
        chk("t5b_err", 64'(err), 64'd1);
        chk("t5b_empty", 64'(fifo_empty), 64'd0);
        chk("t5b_rp", 64'(read_ptr), 64'd1);
        chk("t5b_wp", 64'(write_ptr), 64'd2);
        chk("t5b_dout", data_out, 64'hE0);

        // 5c. Simultaneous at full
        cyc(1'b1, 1'b0, 64'hE1);
        cyc(1'b1, 1'b0, 64'hE2);
        cyc(1'b1, 1'b0, 64'hE3);
        chk("t5c_full", 64'(fifo_full), 64'd1);
        cyc(1'b1, 1'b1, 64'hFF);
        chk("t5c_cnt", 64'(count), 64'd3);
        chk("t5c_full_clr", 64'(fifo_full), 64'd0);
        chk("t5c_wp", 64'(write_ptr), 64'd1);
        chk("t5c_rp", 64'(read_ptr), 64'd2);
        chk("t5c_dout1", data_out, 64'hE1);
        cyc(1'b0, 1'b1, 64'h0);
        chk("t5c_dout2", data_out, 64'hE2);
        cyc(1'b0, 1'b1, 64'h0);
        chk("t5c_dout3", data_out, 64'hE3);
        cyc(1'b0, 1'b1, 64'h0);
        chk("t5c_empty", 64'(fifo_empty), 64'd1);
        chk("t5c_mem1", mem[1], 64'hE0);

        // 6. Reset during a push at count 3
        do_reset();
        cyc(1'b1, 1'b0, 64'hF0);
        cyc(1'b1, 1'b0, 64'hF1);
        cyc(1'b1, 1'b0, 64'hF2);
        chk("t6_cnt3", 64'(count), 64'd3);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 64'hF3);
        rst = 1'b0;
        chk("t6_cnt", 64'(count), 64'd0);
        chk("t6_wp", 64'(write_ptr), 64'd0);
        chk("t6_rp", 64'(read_ptr), 64'd0);
        chk("t6_empty", 64'(fifo_empty), 64'd1);
        chk("t6_full", 64'(fifo_full), 64'd0);
        chk("t6_err", 64'(err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
